flash_bus_ctrl: RTL and testbench
=================================

Name: flash_bus_ctrl

Overview:
- Parametrised controller for the parallel NOR flash on the board; successor to the fixed 8-bit flash bridge.
- Generalised address/data width and programmable setup/strobe/hold timing.
- Adds a status-poll mode that waits on NF_STS with timeout, a power-on NF_RP sequence, an error flag, and separate internal read/write data buses (no internal inout).
- Sits between the scoreboard logic and the NF_* pins.

Parameters:
ADDR_W, 24, flash address width (NF_A, fb_addr)
DATA_W, 8, data width, 8 or 16 only; 8 drives NF_BYTE=0, 16 drives NF_BYTE=1
SETUP_CYC, 1, cycles address/data are valid before CE+OE/WE fall (>=1)
ACC_CYC, 4, strobe-low cycles (>=1)
HOLD_CYC, 1, cycles address/data are held after the strobe rises (>=1)
RP_CYC, 16, cycles NF_RP is held low after reset release (>=1)
STS_SETTLE, 4, cycles ignored after a write before NF_STS is sampled (>=1)
STS_TIMEOUT, 1000000, maximum poll cycles before fb_err
WP_EN, 1, 1 drives NF_WP=0 (boot blocks protected), 0 drives NF_WP=1

Ports:
CLK_50MHZ  in  1  system clock
RST  in  1  reset; asynchronous, active-high
NF_CE, NF_OE, NF_WE, NF_RP  out  1 each  flash strobes, active-low, registered
NF_BYTE, NF_WP  out  1 each  static per parameters
NF_STS  in  1  flash ready (1 = ready); asynchronous
NF_A  out  ADDR_W  flash address, registered
NF_D  inout  DATA_W  flash data
fb_addr  in  ADDR_W  operation address
fb_wdata  in  DATA_W  write data
fb_op  in  2  00 read, 01 write, 10 write then poll STS, 11 reserved
fb_start  in  1  level; sampled only in IDLE with fb_busy=0
fb_rdata  out  DATA_W  read result; holds until the next read completes
fb_busy  out  1  high from reset until RP release, and from the start-accept edge until the DONE edge
fb_done  out  1  one-cycle completion pulse
fb_err  out  1  valid with fb_done; 1 = STS timeout or reserved op

Behaviour:
- Reset values (asynchronous):
  - NF_CE, NF_OE, NF_WE = 1; NF_RP = 0; NF_D = Z; NF_A = 0.
  - fb_busy = 1; fb_done = 0; fb_err = 0; fb_rdata = 0.
  - State = PWRUP.
- Reset mid-operation: strobes rise and NF_D goes Z immediately (no glitch wait); the RP sequence restarts.
- NF_STS passes through a 2-FF synchroniser before use.
- States: PWRUP -> IDLE -> SETUP -> ACCESS -> HOLD -> [SETTLE -> POLL] -> DONE -> IDLE.
- PWRUP: NF_RP=0 for RP_CYC cycles, then NF_RP=1, fb_busy=0, go to IDLE.
- IDLE: if fb_start=1, capture fb_addr, fb_wdata and fb_op, then set fb_busy=1.
  - Op 11: go straight to DONE with fb_err=1; the bus is never touched.
  - Otherwise go to SETUP.
- SETUP (SETUP_CYC cycles):
  - NF_A = captured address.
  - Write ops: NF_D driven from SETUP through HOLD inclusive.
  - Read: NF_D = Z throughout.
- ACCESS (ACC_CYC cycles):
  - NF_CE=0, plus NF_OE=0 (read) or NF_WE=0 (write).
  - Read: NF_D sampled into fb_rdata on the last ACCESS edge.
- HOLD (HOLD_CYC cycles): strobes high, address and write data unchanged.
  - Then go to SETTLE for op 10, else to DONE.
- SETTLE: STS_SETTLE cycles, NF_STS ignored.
- POLL:
  - Synchronised NF_STS=1 -> DONE, fb_err=0.
  - STS_TIMEOUT cycles elapsed without ready -> DONE, fb_err=1.
- DONE (1 cycle): fb_done=1, fb_err valid, NF_D=Z, fb_busy cleared on exit.
- Latency: fb_done rises SETUP_CYC+ACC_CYC+HOLD_CYC+1 edges after the accepting edge (7 at defaults, ops 00/01).
- Back-to-back: fb_start held high starts the next operation on the edge after DONE (one idle cycle minimum).
- fb_start while busy is ignored. fb_addr, fb_wdata and fb_op may change freely after acceptance.
- Never drive NF_D while NF_OE=0; the register transition order guarantees this.
- All cycle counting uses one down-counter. Its width is clog2 of the largest count parameter; it is loaded with N-1 on state entry.

Decomposition:
- Package flash_bus_pkg: op encodings (OP_READ, OP_WRITE, OP_WRITE_POLL, OP_RSVD), state enum, clog2 helper.
- Sub-module flash_wait_counter: loadable down-counter with zero flag; shared by PWRUP, SETUP, ACCESS, HOLD, SETTLE and the POLL timeout.

Test Plan:
- Reset release -> NF_RP=0 for exactly 16 cycles, then 1; fb_busy falls on the same edge; all strobes stay 1 throughout.
- Read 0x000123, flash model returns 0xA5 -> NF_OE/NF_CE low 4 cycles, NF_D never driven, fb_rdata=0xA5, fb_done 7 edges after acceptance, fb_err=0.
- Write 0x00AAAA with 0x55 -> NF_WE low 4 cycles with NF_D=0x55 stable from SETUP through HOLD; fb_done at 7 edges.
- Op 10 with NF_STS low for 50 cycles -> fb_done on the third edge after STS rises (sync + transition), fb_err=0. Repeat with STS stuck low and STS_TIMEOUT=100 -> fb_done with fb_err=1.
- Op 11 -> fb_done on the next edge with fb_err=1; no strobe toggles. fb_start pulsed mid-read is ignored.
- RST asserted during ACCESS of a write -> NF_WE=1 and NF_D=Z in the same cycle (asynchronous); PWRUP sequence repeats.

Source files
------------

// File: rtl/flash_bus_pkg.sv
// Shared types and helpers for the parallel NOR flash bus controller.
// Holds the operation encodings, the controller state set and width helpers.
package flash_bus_pkg;

    typedef enum logic [1:0] {
        OP_READ       = 2'b00,
        OP_WRITE      = 2'b01,
        OP_WRITE_POLL = 2'b10,
        OP_RSVD       = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD,
        ST_SETTLE,
        ST_POLL,
        ST_DONE
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned rem;
        int unsigned bits;
        rem  = (value > 0) ? value - 1 : 0;
        bits = 0;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flash_wait_counter.sv
// Loadable down-counter with a zero flag; every timed phase of the flash
// controller (power-up, bus phases, settle, poll timeout) shares this one.
module flash_wait_counter #(
    parameter int unsigned     WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/flash_bus_ctrl.sv
// Parameterised controller for the board's parallel NOR flash: timed read and
// write cycles, optional status polling with timeout, and a power-on NF_RP pulse.
module flash_bus_ctrl
    import flash_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned ACC_CYC     = 4,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RP_CYC      = 16,
    parameter int unsigned STS_SETTLE  = 4,
    parameter int unsigned STS_TIMEOUT = 1000000,
    parameter int unsigned WP_EN       = 1
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    output logic              NF_CE,
    output logic              NF_OE,
    output logic              NF_WE,
    output logic              NF_RP,
    output logic              NF_BYTE,
    output logic              NF_WP,
    input  logic              NF_STS,
    output logic [ADDR_W-1:0] NF_A,
    inout  wire  [DATA_W-1:0] NF_D,
    input  logic [ADDR_W-1:0] fb_addr,
    input  logic [DATA_W-1:0] fb_wdata,
    input  logic [1:0]        fb_op,
    input  logic              fb_start,
    output logic [DATA_W-1:0] fb_rdata,
    output logic              fb_busy,
    output logic              fb_done,
    output logic              fb_err
);

    localparam int unsigned CNT_MAX = umax(umax(umax(SETUP_CYC, ACC_CYC), umax(HOLD_CYC, RP_CYC)),
                                           umax(STS_SETTLE, STS_TIMEOUT));
    localparam int unsigned CNT_W   = umax(1, clog2(CNT_MAX));

    state_e             state;
    state_e             next_state;
    op_e                op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  d_out;
    logic               d_oe;
    logic               sts_meta;
    logic               sts_sync;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_zero;
    logic               err_next;
    logic               is_write;

    assign is_write = (op_q == OP_WRITE) || (op_q == OP_WRITE_POLL);
    assign NF_D     = d_oe ? d_out : 'z;
    assign NF_BYTE  = (DATA_W == 16);
    assign NF_WP    = (WP_EN != 0) ? 1'b0 : 1'b1;

    flash_wait_counter #(
        .WIDTH   (CNT_W),
        .RST_VAL (CNT_W'(RP_CYC - 1))
    ) u_wait (
        .clk      (CLK_50MHZ),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // NF_STS is driven by the flash with no relation to our clock.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            sts_meta <= 1'b0;
            sts_sync <= 1'b0;
        end else begin
            sts_meta <= NF_STS;
            sts_sync <= sts_meta;
        end
    end

    // NOTE: every signal written here gets a default first so that no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        next_state = state;
        err_next   = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        case (state)
            ST_PWRUP:  if (cnt_zero) next_state = ST_IDLE;
            ST_IDLE: begin
                if (fb_busy) begin
                    next_state = (op_q == OP_RSVD) ? ST_DONE : ST_SETUP;
                    err_next   = (op_q == OP_RSVD);
                end
            end
            ST_SETUP:  if (cnt_zero) next_state = ST_ACCESS;
            ST_ACCESS: if (cnt_zero) next_state = ST_HOLD;
            ST_HOLD: begin
                if (cnt_zero) next_state = (op_q == OP_WRITE_POLL) ? ST_SETTLE : ST_DONE;
            end
            ST_SETTLE: if (cnt_zero) next_state = ST_POLL;
            ST_POLL: begin
                if (sts_sync) begin
                    next_state = ST_DONE;
                end else if (cnt_zero) begin
                    next_state = ST_DONE;
                    err_next   = 1'b1;
                end
            end
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_PWRUP;
        endcase

        if (next_state != state) begin
            cnt_load = 1'b1;
            case (next_state)
                ST_SETUP:  cnt_val = CNT_W'(SETUP_CYC - 1);
                ST_ACCESS: cnt_val = CNT_W'(ACC_CYC - 1);
                ST_HOLD:   cnt_val = CNT_W'(HOLD_CYC - 1);
                ST_SETTLE: cnt_val = CNT_W'(STS_SETTLE - 1);
                ST_POLL:   cnt_val = CNT_W'(STS_TIMEOUT - 1);
                default:   cnt_val = '0;
            endcase
        end
    end

    // Pin registers follow next_state so strobes change on the same edge as the state.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            state    <= ST_PWRUP;
            NF_CE    <= 1'b1;
            NF_OE    <= 1'b1;
            NF_WE    <= 1'b1;
            NF_RP    <= 1'b0;
            NF_A     <= '0;
            d_oe     <= 1'b0;
            d_out    <= '0;
            op_q     <= OP_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            fb_rdata <= '0;
            fb_busy  <= 1'b1;
            fb_done  <= 1'b0;
            fb_err   <= 1'b0;
        end else begin
            state   <= next_state;
            NF_CE   <= (next_state != ST_ACCESS);
            NF_OE   <= !((next_state == ST_ACCESS) && !is_write);
            NF_WE   <= !((next_state == ST_ACCESS) && is_write);
            NF_RP   <= (next_state != ST_PWRUP);
            d_oe    <= is_write && (next_state inside {ST_SETUP, ST_ACCESS, ST_HOLD});
            d_out   <= wdata_q;
            fb_done <= (next_state == ST_DONE);
            fb_err  <= (next_state == ST_DONE) && err_next;

            if (next_state == ST_SETUP) begin
                NF_A <= addr_q;
            end
            if ((state == ST_ACCESS) && (next_state == ST_HOLD) && (op_q == OP_READ)) begin
                fb_rdata <= NF_D;
            end

            if ((state == ST_PWRUP) && (next_state == ST_IDLE)) begin
                fb_busy <= 1'b0;
            end else if ((state == ST_IDLE) && !fb_busy && fb_start) begin
                op_q    <= op_e'(fb_op);
                addr_q  <= fb_addr;
                wdata_q <= fb_wdata;
                fb_busy <= 1'b1;
            end else if (state == ST_DONE) begin
                fb_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flash_bus_ctrl.sv
// Scoreboard bench for flash_bus_ctrl: directed operations push expected
// completions; a negedge monitor pops and compares on every fb_done.
module tb_flash_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        nf_ce, nf_oe, nf_we, nf_rp, nf_byte, nf_wp;
    logic        nf_sts;
    logic [23:0] nf_a;
    wire  [7:0]  nf_d;
    logic [23:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic [1:0]  fb_op;
    logic        fb_start;
    logic [7:0]  fb_rdata;
    logic        fb_busy, fb_done, fb_err;
    logic [7:0]  flash_q;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         done_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   oe_low = 0, we_low = 0, ce_low = 0, d55 = 0;
    logic [23:0] a_seen = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash model: fixed byte at 0x000123, address-derived data elsewhere.
    always_comb flash_q = (nf_a == 24'h000123) ? 8'hA5 : (nf_a[7:0] ^ 8'h3C);
    assign nf_d = (!nf_oe && !nf_ce) ? flash_q : 8'bz;

    flash_bus_ctrl #(
        .STS_TIMEOUT (100)
    ) dut (
        .CLK_50MHZ (clk),
        .RST       (rst),
        .NF_CE     (nf_ce),
        .NF_OE     (nf_oe),
        .NF_WE     (nf_we),
        .NF_RP     (nf_rp),
        .NF_BYTE   (nf_byte),
        .NF_WP     (nf_wp),
        .NF_STS    (nf_sts),
        .NF_A      (nf_a),
        .NF_D      (nf_d),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .fb_op     (fb_op),
        .fb_start  (fb_start),
        .fb_rdata  (fb_rdata),
        .fb_busy   (fb_busy),
        .fb_done   (fb_done),
        .fb_err    (fb_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && fb_done) begin
            check("done_expected", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("rdata", fb_rdata, e.rdata);
                check("err", fb_err, e.err);
                check("done_cyc", cyc, e.done_cyc);
            end
        end
        if (!nf_oe) oe_low++;
        if (!nf_we) we_low++;
        if (!nf_ce) begin
            ce_low++;
            a_seen = nf_a;
        end
        if (nf_oe && nf_d == 8'h55) d55++;
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        while (fb_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (fb_busy) check(tag, fb_busy, 0);
    endtask

    task automatic pwrup_check(input string tag);
        int   n = 0;
        logic busy_ok = 1'b1;
        logic strobe_ok = 1'b1;
        while (nf_rp == 1'b0 && n < 100) begin
            if (!fb_busy) busy_ok = 1'b0;
            if (!(nf_ce && nf_oe && nf_we)) strobe_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        check({tag, "_rp_low_cycles"}, n, 16);
        check({tag, "_busy_during_rp"}, busy_ok, 1);
        check({tag, "_strobes_idle"}, strobe_ok, 1);
        check({tag, "_busy_at_rp_rise"}, fb_busy, 0);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp_rdata, input logic exp_err, input int lat,
                         output int acc);
        wait_idle("idle_before_op");
        fb_op    = op;
        fb_addr  = addr;
        fb_wdata = wdata;
        fb_start = 1'b1;
        acc      = cyc + 1;
        sb_q.push_back('{rdata: exp_rdata, err: exp_err, done_cyc: acc + lat});
        @(negedge clk);
        fb_start = 1'b0;
        fb_addr  = ~addr;
        fb_wdata = ~wdata;
        fb_op    = 2'b11;
    endtask

    initial begin
        int acc;
        int oe0, we0, ce0, d0;
        rst      = 1'b0;
        nf_sts   = 1'b1;
        fb_start = 1'b0;
        fb_op    = 2'b00;
        fb_addr  = '0;
        fb_wdata = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_ce", nf_ce, 1);
        check("rst_oe", nf_oe, 1);
        check("rst_we", nf_we, 1);
        check("rst_rp", nf_rp, 0);
        check("rst_a", nf_a, 0);
        check("rst_busy", fb_busy, 1);
        check("rst_done", fb_done, 0);
        check("rst_err", fb_err, 0);
        check("rst_rdata", fb_rdata, 0);
        check("nf_byte", nf_byte, 0);
        check("nf_wp", nf_wp, 0);

        rst = 1'b0;
        pwrup_check("pwrup");

        // Read with a stray fb_start pulse while busy; wdata 0x55 must never reach the bus.
        oe0 = oe_low; we0 = we_low; ce0 = ce_low; d0 = d55;
        do_op(2'b00, 24'h000123, 8'h55, 8'hA5, 1'b0, 7, acc);
        repeat (2) @(negedge clk);
        fb_start = 1'b1;
        @(negedge clk);
        fb_start = 1'b0;
        wait_idle("read_idle");
        check("read_oe_low", oe_low - oe0, 4);
        check("read_ce_low", ce_low - ce0, 4);
        check("read_we_low", we_low - we0, 0);
        check("read_addr", a_seen, 24'h000123);
        check("read_no_drive", d55 - d0, 0);

        // Write: fb_rdata must hold the previous read result.
        oe0 = oe_low; we0 = we_low; ce0 = ce_low; d0 = d55;
        do_op(2'b01, 24'h00AAAA, 8'h55, 8'hA5, 1'b0, 7, acc);
        wait_idle("write_idle");
        check("write_we_low", we_low - we0, 4);
        check("write_ce_low", ce_low - ce0, 4);
        check("write_oe_low", oe_low - oe0, 0);
        check("write_addr", a_seen, 24'h00AAAA);
        check("write_data_cycles", d55 - d0, 6);

        // Back-to-back reads with fb_start held high.
        fb_op    = 2'b00;
        fb_addr  = 24'h000123;
        fb_start = 1'b1;
        acc      = cyc + 1;
        sb_q.push_back('{rdata: 8'hA5, err: 1'b0, done_cyc: acc + 7});
        sb_q.push_back('{rdata: 8'h7E, err: 1'b0, done_cyc: acc + 16});
        @(negedge clk);
        fb_addr = 24'h000042;
        repeat (9) @(negedge clk);
        fb_start = 1'b0;
        wait_idle("b2b_idle");

        // Reserved op: immediate error completion, bus untouched.
        oe0 = oe_low; we0 = we_low; ce0 = ce_low; d0 = d55;
        do_op(2'b11, 24'h000777, 8'h55, 8'h7E, 1'b1, 1, acc);
        wait_idle("rsvd_idle");
        check("rsvd_ce_low", ce_low - ce0, 0);
        check("rsvd_oe_low", oe_low - oe0, 0);
        check("rsvd_we_low", we_low - we0, 0);
        check("rsvd_no_drive", d55 - d0, 0);

        // Write then poll: STS rises 50 cycles after acceptance.
        nf_sts = 1'b0;
        we0 = we_low;
        do_op(2'b10, 24'h000010, 8'h33, 8'h7E, 1'b0, 53, acc);
        repeat (50) @(negedge clk);
        nf_sts = 1'b1;
        wait_idle("poll_idle");
        check("poll_we_low", we_low - we0, 4);

        // Write then poll with STS stuck low: timeout after 100 poll cycles.
        nf_sts = 1'b0;
        do_op(2'b10, 24'h000020, 8'h44, 8'h7E, 1'b1, 111, acc);
        wait_idle("timeout_idle");
        nf_sts = 1'b1;

        // Reset during the strobe phase of a write.
        fb_op    = 2'b01;
        fb_addr  = 24'h00AAAA;
        fb_wdata = 8'h55;
        fb_start = 1'b1;
        @(negedge clk);
        fb_start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_we_active", nf_we, 0);
        check("abort_d_driven", nf_d, 8'h55);
        #2 rst = 1'b1;
        #1;
        check("abort_we", nf_we, 1);
        check("abort_ce", nf_ce, 1);
        check("abort_rp", nf_rp, 0);
        check("abort_busy", fb_busy, 1);
        check("abort_d_released", 32'(nf_d != 8'h55), 1);
        @(negedge clk);
        rst = 1'b0;
        pwrup_check("repwr");

        do_op(2'b00, 24'h000123, 8'h00, 8'hA5, 1'b0, 7, acc);
        wait_idle("final_idle");
        repeat (2) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
